// File: rtl/lock_mem_port_ctrl.sv
// lock_mem_port_ctrl
// Per-core sequencer between one core and one port of the shared two-port lock
// memory. It accepts a one-cycle LOAD / STORE / FADD request, asks the lock
// arbiter for exclusive access (need_lock), waits until its lock bit is clear,
// then runs the memory port (read-modify-write for FADD) and pulses done.
// Optional build macro: LOCK_TIMEOUT_EN bounds the lock wait to TIMEOUT cycles
// and reports an abort on err. Without it the wait is unbounded and err is 0.
module lock_mem_port_ctrl #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              need_lock,
  input  logic              lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_RDWAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_FADD  = 2'b10;
  // Last RDWAIT count before mem_q holds the addressed word.
  localparam logic [1:0] RD_LAST  = 2'(RD_LAT - 1);

  state_t            state_reg;
  logic [1:0]        op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  // High during the first WAIT cycle: the arbiter's lock lags need_lock by one cycle.
  logic              settle_reg;
  logic [1:0]        rd_cnt_reg;

`ifdef LOCK_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [TMO_W-1:0]  wait_cnt_reg;
`else
  // TIMEOUT only sizes the wait counter, which does not exist in this build.
  logic              timeout_unused;
  assign timeout_unused = (TIMEOUT != 0);
  assign err = 1'b0;
`endif

  // Access sequencer: each output register is loaded on the edge that enters its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      op_reg     <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      settle_reg <= 1'b0;
      rd_cnt_reg <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= '0;
      need_lock  <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_wren   <= 1'b0;
`ifdef LOCK_TIMEOUT_EN
      err          <= 1'b0;
      wait_cnt_reg <= '0;
`endif
    end else begin
      done     <= 1'b0;
      mem_wren <= 1'b0;
`ifdef LOCK_TIMEOUT_EN
      err      <= 1'b0;
`endif
      case (state_reg)
        S_IDLE: begin
          if (req) begin
            op_reg     <= op;
            addr_reg   <= addr;
            wdata_reg  <= wdata;
            settle_reg <= 1'b1;
            busy       <= 1'b1;
            need_lock  <= 1'b1;
            state_reg  <= S_WAIT;
`ifdef LOCK_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
          end
        end
        S_WAIT: begin
          settle_reg <= 1'b0;
`ifdef LOCK_TIMEOUT_EN
          wait_cnt_reg <= wait_cnt_reg + TMO_W'(1);
`endif
          if (!settle_reg && !lock) begin
            mem_addr <= addr_reg;
            if (op_reg == OP_STORE) begin
              mem_data  <= wdata_reg;
              mem_wren  <= 1'b1;
              state_reg <= S_WRITE;
            end else begin
              state_reg <= S_READ;
            end
          end
`ifdef LOCK_TIMEOUT_EN
          else if (!settle_reg && wait_cnt_reg >= TMO_W'(TIMEOUT)) begin
            // Give up: release the arbiter and return idle without touching memory.
            err       <= 1'b1;
            need_lock <= 1'b0;
            busy      <= 1'b0;
            state_reg <= S_IDLE;
          end
`endif
        end
        S_READ: begin
          rd_cnt_reg <= '0;
          state_reg  <= S_RDWAIT;
        end
        S_RDWAIT: begin
          if (rd_cnt_reg == RD_LAST) begin
            rdata <= mem_q;
            if (op_reg == OP_FADD) begin
              // Sum wraps at DATA_W bits; the carry is discarded.
              mem_data  <= mem_q + wdata_reg;
              mem_wren  <= 1'b1;
              state_reg <= S_WRITE;
            end else begin
              done      <= 1'b1;
              need_lock <= 1'b0;
              state_reg <= S_DONE;
            end
          end else begin
            rd_cnt_reg <= rd_cnt_reg + 2'd1;
          end
        end
        S_WRITE: begin
          done      <= 1'b1;
          need_lock <= 1'b0;
          state_reg <= S_DONE;
        end
        S_DONE: begin
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          need_lock <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_mem_port_ctrl.sv
// tb_lock_mem_port_ctrl
// Drives lock_mem_port_ctrl against a simple synchronous RAM and checks every
// cycle against a transaction-level timeline model: a request accepted in cycle
// c is granted in the first cycle g >= c+2 with lock low; the write cycle and
// done cycle follow from g by fixed offsets per operation. Expected read data
// comes from a reference copy of memory updated once per completed access.
module tb_lock_mem_port_ctrl;
  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int RDL = 1;
  localparam int TMO = 8;
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_FADD  = 2'b10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          lock = 1'b0;
  logic          busy, done, err, need_lock, mem_wren;
  logic [DW-1:0] rdata, mem_data, mem_q;
  logic [AW-1:0] mem_addr;

  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [DW-1:0] pre_d = '0;
  logic [DW-1:0] ram [64];
  logic [DW-1:0] ref_mem [64];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Timeline model of the one outstanding access.
  bit            act = 1'b0;
  bit            granted = 1'b0;
  int            c_req = 0;
  int            wr_cyc = -1;
  int            dn_cyc = -1;
  int            err_cyc = -1;
  logic [1:0]    t_op = 2'b00;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] exp_rd = '0;
  logic [DW-1:0] exp_wd = '0;
  logic [DW-1:0] last_rdata = '0;
  int            last_done_cyc = -1;
  int            wr_count = 0;
  int            err_count = 0;

  lock_mem_port_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RDL), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .err(err),
    .need_lock(need_lock), .lock(lock),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  initial forever #5 clk = ~clk;

  // Memory port: one-cycle registered read, write on mem_wren, preload path for setup.
  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (mem_wren) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, required %h", name, cyc, got, want);
    end
  endtask

  task automatic check_outputs();
    logic e_busy, e_nl, e_done, e_wren;
    if (act && granted && cyc > dn_cyc) begin
      if (t_op == OP_STORE || t_op == OP_FADD) ref_mem[t_addr] = exp_wd;
      act = 1'b0;
    end
    e_busy = 1'b0; e_nl = 1'b0; e_done = 1'b0; e_wren = 1'b0;
    if (act) begin
      if (granted) begin
        e_busy = (cyc <= dn_cyc);
        e_nl   = (cyc < dn_cyc);
        e_done = (cyc == dn_cyc);
        e_wren = (cyc == wr_cyc);
      end else begin
        e_busy = 1'b1;
        e_nl   = 1'b1;
      end
    end
    chk("busy", 32'(busy), 32'(e_busy));
    chk("need_lock", 32'(need_lock), 32'(e_nl));
    chk("done", 32'(done), 32'(e_done));
    chk("mem_wren", 32'(mem_wren), 32'(e_wren));
    chk("err", 32'(err), 32'(cyc == err_cyc));
    if (e_wren) begin
      chk("mem_addr", 32'(mem_addr), 32'(t_addr));
      chk("mem_data", mem_data, exp_wd);
    end
    if (e_done) begin
      chk("rdata_done", rdata, exp_rd);
      last_rdata = exp_rd;
    end else if (!e_busy) begin
      chk("rdata_held", rdata, last_rdata);
    end
    if (done === 1'b1) last_done_cyc = cyc;
    if (mem_wren === 1'b1) wr_count++;
    if (err === 1'b1) err_count++;
  endtask

  task automatic model_advance();
    if (!act) begin
      if (rst_n && req) begin
        act = 1'b1; granted = 1'b0; c_req = cyc;
        t_op = op; t_addr = addr; wr_cyc = -1; dn_cyc = -1;
        exp_rd = (op == OP_STORE) ? last_rdata : ref_mem[addr];
        exp_wd = (op == OP_STORE) ? wdata : ref_mem[addr] + wdata;
      end
    end else if (!granted && cyc >= c_req + 2) begin
      if (!lock) begin
        granted = 1'b1;
        if (t_op == OP_STORE) begin
          wr_cyc = cyc + 1; dn_cyc = cyc + 2;
        end else if (t_op == OP_FADD) begin
          wr_cyc = cyc + 2 + RDL; dn_cyc = cyc + 3 + RDL;
        end else begin
          dn_cyc = cyc + 2 + RDL;
        end
      end
`ifdef LOCK_TIMEOUT_EN
      else if (cyc - (c_req + 1) >= TMO) begin
        act = 1'b0;
        err_cyc = cyc + 1;
      end
`endif
    end
  endtask

  // One clock cycle: check this cycle's outputs, then drive and model this cycle's inputs.
  task automatic cycle(input logic req_i, input logic [1:0] op_i, input logic [AW-1:0] addr_i,
                       input logic [DW-1:0] wd_i, input logic lock_i);
    @(negedge clk);
    cyc++;
    check_outputs();
    req = req_i; op = op_i; addr = addr_i; wdata = wd_i; lock = lock_i;
    model_advance();
  endtask

  // lmode: 0 lock low, 1 lock high for 10 cycles after need_lock rises,
  // 2 lock high only in the settle cycle, 3 lock stuck high.
  task automatic run_txn(input logic [1:0] o, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int lmode, input bit rst_at_write, output int lat, output int nwr);
    int c0, wr0, r;
    logic l;
    wr0 = wr_count;
    last_done_cyc = -1;
    cycle(1'b1, o, a, d, 1'b0);
    c0 = cyc;
    for (int k = 0; k < 300 && act; k++) begin
      r = cyc + 1 - c0;
      case (lmode)
        1: l = (r >= 1 && r <= 10);
        2: l = (r == 1);
        3: l = 1'b1;
        default: l = 1'b0;
      endcase
      cycle(1'b0, 2'b00, '0, '0, l);
      if (rst_at_write && act && granted && cyc == wr_cyc) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mem_wren", 32'(mem_wren), 32'd0);
        chk("rst_need_lock", 32'(need_lock), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        act = 1'b0;
        last_rdata = '0;
        cycle(1'b0, 2'b00, '0, '0, 1'b0);
        rst_n = 1'b1;
        break;
      end
    end
    chk("txn_bound", 32'(act), 32'd0);
    cycle(1'b0, 2'b00, '0, '0, 1'b0);
    lat = (last_done_cyc < c0) ? -1 : last_done_cyc - c0;
    nwr = wr_count - wr0;
  endtask

  initial begin
    int lat, nwr, e0;
    logic [31:0] r1, r2, r3, r4;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_need_lock", 32'(need_lock), 32'd0);
    chk("reset_mem_wren", 32'(mem_wren), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_mem_data", mem_data, 32'd0);

    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pre_we = 1'b1;
      pre_a = AW'(i);
      pre_d = (i == 9) ? 32'hFFFF_FFFF : $urandom;
      ref_mem[i] = pre_d;
    end
    @(negedge clk);
    pre_we = 1'b0;
    rst_n = 1'b1;

    run_txn(OP_STORE, 6'd5, 32'hDEAD_BEEF, 0, 1'b0, lat, nwr);
    chk("t1_latency", lat, 32'd4);
    chk("t1_writes", nwr, 32'd1);
    chk("t1_ram5", ram[5], 32'hDEAD_BEEF);

    run_txn(OP_LOAD, 6'd5, 32'h0, 0, 1'b0, lat, nwr);
    chk("t2_latency", lat, 32'd5);
    chk("t2_writes", nwr, 32'd0);
    chk("t2_rdata", rdata, 32'hDEAD_BEEF);

    run_txn(OP_FADD, 6'd9, 32'd2, 0, 1'b0, lat, nwr);
    chk("t3_latency", lat, 32'd6);
    chk("t3_writes", nwr, 32'd1);
    chk("t3_rdata", rdata, 32'hFFFF_FFFF);
    chk("t3_ram9_wrap", ram[9], 32'h0000_0001);

    run_txn(OP_LOAD, 6'd5, 32'h0, 1, 1'b0, lat, nwr);
    chk("t4_blocked_latency", lat, 32'd14);
    chk("t4_blocked_writes", nwr, 32'd0);
    run_txn(OP_LOAD, 6'd9, 32'h0, 2, 1'b0, lat, nwr);
    chk("t4_settle_latency", lat, 32'd5);
    chk("t4_settle_rdata", rdata, 32'h0000_0001);

    run_txn(OP_FADD, 6'd9, 32'd5, 0, 1'b1, lat, nwr);
    chk("t5_no_write", ram[9], 32'h0000_0001);
    chk("t5_rdata_reset", rdata, 32'h0);
    run_txn(OP_LOAD, 6'd9, 32'h0, 0, 1'b0, lat, nwr);
    chk("t5_after_latency", lat, 32'd5);
    chk("t5_after_rdata", rdata, 32'h0000_0001);

`ifdef LOCK_TIMEOUT_EN
    e0 = err_count;
    run_txn(OP_STORE, 6'd3, 32'h1234_5678, 3, 1'b0, lat, nwr);
    chk("t6_err_pulses", err_count - e0, 32'd1);
    chk("t6_no_done", lat, 32'hFFFF_FFFF);
    chk("t6_no_write", nwr, 32'd0);
    chk("t6_need_lock", 32'(need_lock), 32'd0);
    run_txn(OP_LOAD, 6'd3, 32'h0, 0, 1'b0, lat, nwr);
    chk("t6_after_latency", lat, 32'd5);
`else
    e0 = err_count;
    run_txn(OP_LOAD, 6'd3, 32'h0, 1, 1'b0, lat, nwr);
    chk("no_timeout_err", err_count - e0, 32'd0);
`endif

    for (int k = 0; k < 3000; k++) begin
      r1 = $urandom; r2 = $urandom; r3 = $urandom; r4 = $urandom;
      cycle(r1[1:0] == 2'b00, r2[1:0], AW'(r2[5:2]), r3, r4[1:0] == 2'b00);
    end
    for (int k = 0; k < 300 && act; k++) cycle(1'b0, 2'b00, '0, '0, 1'b0);
    cycle(1'b0, 2'b00, '0, '0, 1'b0);
    chk("drain_idle", 32'(act), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
